// File: rtl/ren_img_loader.sv
// ren_img_loader: Wishbone write master that packs an 8-bit pixel stream into 24-bit image words
// and optionally kicks the convolution accelerator with a start write afterwards.
module ren_img_loader #(
  parameter logic [7:0]  SLV_ADDR    = 8'h30,
  parameter logic [1:0]  START_OFS   = 2'd0,
  parameter logic [31:0] START_VAL   = 32'h1,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_start,
  input  logic [6:0]  cfg_words,
  input  logic        cfg_kick,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FILL, WRITE, KICK, FIN} state_t;
  state_t state, nxt;
  logic [6:0] words;
  logic kick;
  logic [5:0] idx;
  logic [1:0] cnt;
  logic [23:0] pix;
  logic [TW-1:0] tcnt;
  logic err_q;
  logic tout;
  logic last;
  assign tout = tcnt == TW'(ACK_TIMEOUT - 1);
  assign last = ({1'b0, idx} + 7'd1) == words;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o = wbm_cyc_o;
  assign err = err_q;
  always_comb begin
    nxt = state;
    pix_ready = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    done = 1'b0;
    busy = state inside {FILL, WRITE, KICK};
    case (state)
      IDLE: if (cfg_start) nxt = (cfg_words == 7'd0) ? (cfg_kick ? KICK : FIN) : FILL;
      FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && cnt == 2'd2) nxt = WRITE;
      end
      WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_sel_o = 4'b0111;
        wbm_adr_o = {SLV_ADDR, 14'b0, 2'b01, idx, 2'b00};
        wbm_dat_o = {8'h00, pix};
        if (wbm_ack_i) nxt = last ? (kick ? KICK : FIN) : FILL;
        else if (tout) nxt = IDLE;
      end
      KICK: begin
        wbm_cyc_o = 1'b1;
        wbm_sel_o = 4'b1111;
        wbm_adr_o = {SLV_ADDR, 14'b0, 2'b00, 4'b0000, START_OFS, 2'b00};
        wbm_dat_o = START_VAL;
        if (wbm_ack_i) nxt = FIN;
        else if (tout) nxt = IDLE;
      end
      FIN: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      words <= '0;
      kick <= 1'b0;
      idx <= '0;
      cnt <= '0;
      pix <= '0;
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= wbm_cyc_o && !wbm_ack_i && tout;
      // stays zero outside a bus cycle, so it is already clear whenever WRITE/KICK is entered
      tcnt <= (wbm_cyc_o && nxt == state) ? tcnt + 1'b1 : '0;
      if (state == IDLE && cfg_start) begin
        words <= (cfg_words > 7'd64) ? 7'd64 : cfg_words;
        kick <= cfg_kick;
        idx <= '0;
        cnt <= '0;
      end
      if (pix_ready && pix_valid) begin
        pix[{cnt, 3'b000} +: 8] <= pix_data;
        cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 1'b1;
      end
      if (state == WRITE && wbm_ack_i) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_ren_img_loader.sv
// tb_ren_img_loader: directed bench with a write scoreboard fed by stimulus and drained by a slave monitor.
module tb_ren_img_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic [6:0] cfg_words = '0;
  logic cfg_kick = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic pix_ready, cyc, stb, we, busy, done, err;
  logic [3:0] sel;
  logic [31:0] adr, dat;
  logic ack = 1'b0;

  always #5 clk = ~clk;

  ren_img_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .cfg_start(cfg_start), .cfg_words(cfg_words),
    .cfg_kick(cfg_kick), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr),
    .wbm_dat_o(dat), .wbm_ack_i(ack), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
  wr_t expq[$];
  wr_t first;
  int nvec = 0, nerr = 0;
  int done_cnt = 0, err_cnt = 0, cyc_cycles = 0, wr_cnt = 0;
  bit ack_en = 1'b1, ack_force = 1'b0;
  int ack_min = 1, ack_max = 1, wcnt = 0, dly = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave model and monitor: ack is decided at negedge, so the handshake lands on the next posedge
  always @(negedge clk) begin
    wr_t e;
    if (done) begin
      done_cnt++;
      check("done_all_written", 72'(expq.size()), 72'd0);
    end
    if (err) err_cnt++;
    if (cyc) cyc_cycles++;
    if (cyc && stb) begin
      if (wcnt == 0) begin
        first = {adr, dat, sel};
        dly = $urandom_range(ack_max, ack_min);
      end
      if (ack_en && wcnt >= dly) begin
        ack = 1'b1;
        wr_cnt++;
        wcnt = 0;
        check("we_high", 72'(we), 72'd1);
        check("held_stable", 72'({adr, dat, sel}), 72'(first));
        if (expq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: got adr %h dat %h sel %h expected none", adr, dat, sel);
        end else begin
          e = expq.pop_front();
          check("write", 72'({adr, dat, sel}), 72'(e));
        end
      end else begin
        ack = 1'b0;
        wcnt++;
      end
    end else begin
      ack = ack_force;
      wcnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] w, input logic k);
    cfg_words = w;
    cfg_kick = k;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b[$], input bit rnd);
    int guard;
    bit acc;
    guard = 0;
    foreach (b[i]) begin
      acc = 1'b0;
      while (!acc && guard < 5000) begin
        pix_data = b[i];
        pix_valid = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
        @(negedge clk);
        acc = pix_valid && pix_ready;
        @(posedge clk);
        #1;
        guard++;
      end
    end
    pix_valid = 1'b0;
    check("feed_bound", 72'(guard < 5000), 72'd1);
  endtask

  task automatic wait_end(input string name, input int d0, input int e0, input int bound);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < bound) begin
      tick(1);
      n++;
    end
    check(name, 72'(n < bound), 72'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bq[$];
    int d0, e0, w0, c0;
    tick(3);
    check("reset_outputs", 72'({cyc, stb, we, busy, done, err, pix_ready, sel, adr, dat}), 72'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_outputs", 72'({cyc, stb, we, busy, done, err, pix_ready}), 72'd0);

    // ack while idle must be ignored
    w0 = wr_cnt; d0 = done_cnt;
    ack_force = 1'b1;
    tick(3);
    ack_force = 1'b0;
    check("idle_ack_ignored", 72'({wr_cnt - w0, done_cnt - d0, busy}), 72'd0);

    // two words, no kick, ack one cycle after stb
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    ack_min = 1; ack_max = 1;
    expq.push_back({32'h3000_0100, 32'h0003_0201, 4'h7});
    expq.push_back({32'h3000_0104, 32'h0006_0504, 4'h7});
    start(7'd2, 1'b0);
    check("busy_after_start", 72'(busy), 72'd1);
    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    feed(bq, 1'b0);
    wait_end("w2_end", d0, e0, 200);
    tick(1);
    check("w2_done_writes_err", 72'({32'(done_cnt - d0), 32'(wr_cnt - w0), 8'(err_cnt - e0)}), {32'd1, 32'd2, 8'd0});
    check("w2_busy_low", 72'(busy), 72'd0);

    // one word plus kick; a second cfg_start while busy is ignored
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    expq.push_back({32'h3000_0100, 32'h00CC_BBAA, 4'h7});
    expq.push_back({32'h3000_0000, 32'h0000_0001, 4'hF});
    start(7'd1, 1'b1);
    start(7'd3, 1'b0);
    bq = {8'hAA, 8'hBB, 8'hCC};
    feed(bq, 1'b0);
    wait_end("kick_end", d0, e0, 200);
    tick(3);
    check("kick_done_writes", 72'({32'(done_cnt - d0), 32'(wr_cnt - w0), 8'(err_cnt - e0)}), {32'd1, 32'd2, 8'd0});

    // zero words, no kick: done without any bus cycle
    d0 = done_cnt; e0 = err_cnt; c0 = cyc_cycles;
    start(7'd0, 1'b0);
    wait_end("w0_end", d0, e0, 3);
    tick(2);
    check("w0_single_done_no_cyc", 72'({32'(done_cnt - d0), 32'(cyc_cycles - c0)}), {32'd1, 32'd0});

    // saturating word count, random valid, random ack delay
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    ack_min = 0; ack_max = 5;
    bq = {};
    for (int i = 0; i < 192; i++) bq.push_back(8'(i * 37 + 11));
    for (int w = 0; w < 64; w++)
      expq.push_back({32'h3000_0100 + 32'(4 * w), {8'h00, bq[3*w+2], bq[3*w+1], bq[3*w]}, 4'h7});
    start(7'd127, 1'b0);
    feed(bq, 1'b1);
    wait_end("w64_end", d0, e0, 2000);
    check("w64_done_writes", 72'({32'(done_cnt - d0), 32'(wr_cnt - w0), 8'(err_cnt - e0)}), {32'd1, 32'd64, 8'd0});
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_extra_consume", 72'(pix_ready), 72'd0);
    end
    tick(1);
    pix_valid = 1'b0;

    // slave never acks
    ack_min = 1; ack_max = 1;
    ack_en = 1'b0;
    d0 = done_cnt; e0 = err_cnt; c0 = cyc_cycles;
    start(7'd1, 1'b0);
    bq = {8'h07, 8'h08, 8'h09};
    feed(bq, 1'b0);
    wait_end("timeout_end", d0, e0, 100);
    tick(3);
    check("timeout_cyc_len", 72'(cyc_cycles - c0), 72'd16);
    check("timeout_err_no_done", 72'({32'(err_cnt - e0), 32'(done_cnt - d0)}), {32'd1, 32'd0});
    check("timeout_idle", 72'({busy, cyc, stb}), 72'd0);

    // async reset during a stalled write, then a clean restart at idx 0
    start(7'd2, 1'b0);
    bq = {8'h20, 8'h21, 8'h22};
    feed(bq, 1'b0);
    tick(2);
    check("pre_reset_cyc", 72'({cyc, stb, busy}), 72'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 72'({cyc, stb, busy}), 72'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    ack_en = 1'b1;
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    expq.push_back({32'h3000_0100, 32'h0012_1110, 4'h7});
    start(7'd1, 1'b0);
    bq = {8'h10, 8'h11, 8'h12};
    feed(bq, 1'b0);
    wait_end("restart_end", d0, e0, 200);
    tick(1);
    check("restart_done_writes", 72'({32'(done_cnt - d0), 32'(wr_cnt - w0), 8'(err_cnt - e0)}), {32'd1, 32'd1, 8'd0});
    check("scoreboard_empty", 72'(expq.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
